// File: rtl/rdq32_reader_if.sv
// Handshake bundle between a queue writer/reader and rdq32_reader.
// The master drives pushes and read acceptance; the slave is the queue.
interface rdq32_reader_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             wr_full;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic [CW-1:0]    count;
    logic             ovf;

    modport master (
        output wr_en, wr_data, rd_ready,
        input  wr_full, rd_valid, rd_data, count, ovf
    );

    modport slave (
        input  wr_en, wr_data, rd_ready,
        output wr_full, rd_valid, rd_data, count, ovf
    );
endinterface

// File: rtl/rdq32_reader.sv
// Small FIFO feeding a valid/ready reader, with sticky overflow flag.
// RDQ32_BYPASS_EN enables a zero-latency pass-through when the queue is empty.
module rdq32_reader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input logic         clk,
    input logic         r,
    rdq32_reader_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } state_t;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf;

    state_t w_state;
    logic   w_valid;
    logic   w_thru;
    logic   w_pop;
    logic   w_push;
    logic   w_do_push;
    logic   w_do_pop;

    // Occupancy class comes straight from count; nothing extra is stored.
    always_comb begin
        w_state = PARTIAL;
        if (r_count == '0)
            w_state = EMPTY;
        else if (r_count == CW'(DEPTH))
            w_state = FULL;
    end

`ifdef RDQ32_BYPASS_EN
    assign w_valid     = (w_state != EMPTY) | bus.wr_en;
    assign w_thru      = (w_state == EMPTY) & bus.wr_en & bus.rd_ready;
    assign bus.rd_data = (w_state == EMPTY) ? bus.wr_data : r_mem[r_rd_ptr];
`else
    assign w_valid     = (w_state != EMPTY);
    assign w_thru      = 1'b0;
    assign bus.rd_data = r_mem[r_rd_ptr];
`endif

    assign w_pop     = w_valid & bus.rd_ready;
    assign w_push    = bus.wr_en & ((w_state != FULL) | w_pop);
    // A pass-through word never touches storage, pointers or count.
    assign w_do_push = w_push & ~w_thru;
    assign w_do_pop  = w_pop & ~w_thru;

    assign bus.rd_valid = w_valid;
    assign bus.wr_full  = (w_state == FULL);
    assign bus.count    = r_count;
    assign bus.ovf      = r_ovf;

    always_ff @(posedge clk) begin
        if (!r) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_do_push && !w_do_pop)
                r_count <= r_count + CW'(1);
            else if (w_do_pop && !w_do_push)
                r_count <= r_count - CW'(1);
            if (bus.wr_en && (w_state == FULL) && !w_pop)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r && w_do_push)
            r_mem[r_wr_ptr] <= bus.wr_data;
    end
endmodule

// File: tb/tb_rdq32_reader.sv
// Random and directed bench for rdq32_reader with a queue-based reference
// model and a scoreboard consumed by an independent read monitor.
module tb_rdq32_reader;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic r   = 1'b0;
    always #5 clk = ~clk;

    rdq32_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    rdq32_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .r   (r),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit primed = 1'b0;

    logic [WIDTH-1:0] mq [$];
    logic [WIDTH-1:0] sb [$];
    bit               movf = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check visible state, advance the model.
    task automatic cyc(input logic rst_n, input logic we,
                       input logic [WIDTH-1:0] wd, input logic rr);
        bit empty, full, ev, pop, push, thru;
        @(negedge clk);
        r           = rst_n;
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_ready = rr;
        #1;
        empty = (mq.size() == 0);
        full  = (mq.size() == DEPTH);
`ifdef RDQ32_BYPASS_EN
        ev   = !empty || we;
        thru = empty && we && rr;
`else
        ev   = !empty;
        thru = 1'b0;
`endif
        if (primed) begin
            chk("count", 64'(bus.count), 64'(mq.size()));
            chk("rd_valid", 64'(bus.rd_valid), 64'(ev));
            chk("wr_full", 64'(bus.wr_full), 64'(full));
            chk("ovf", 64'(bus.ovf), 64'(movf));
        end
        if (!rst_n) begin
            mq.delete();
            sb.delete();
            movf = 1'b0;
            primed = 1'b1;
        end else begin
            pop  = ev && rr;
            push = we && (!full || pop);
            if (push)
                sb.push_back(wd);
            if (!thru) begin
                if (pop)
                    void'(mq.pop_front());
                if (push)
                    mq.push_back(wd);
            end
            if (we && full && !pop)
                movf = 1'b1;
        end
    endtask

    // Read monitor: every accepted word must be the oldest expected one.
    initial begin
        logic [WIDTH-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (primed && r && bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("rd_underflow", 64'(bus.rd_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("rd_data", 64'(bus.rd_data), 64'(e));
                end
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++)
            cyc(1'b1, 1'b0, '0, 1'b1);
    endtask

    initial begin
        bus.wr_en    = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        cyc(1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b1, 32'h5555_5555, 1'b1);

        // three pushes held, head stays first word
        cyc(1'b1, 1'b1, 32'h1111_1111, 1'b0);
        cyc(1'b1, 1'b1, 32'h2222_2222, 1'b0);
        cyc(1'b1, 1'b1, 32'h3333_3333, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0);
        drain();

        // overflow on full, dropped word must never appear
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, 1'b1, 32'hB000_0000 + 32'(i), 1'b0);
        cyc(1'b1, 1'b1, 32'hBAD0_BAD0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0);
        drain();
        cyc(1'b1, 1'b0, '0, 1'b0);

        // full with simultaneous push and pop, wraps pointers
        cyc(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, 1'b1, 32'hC000_0000 + 32'(i), 1'b0);
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 1'b1, 32'hA0 + 32'(i), 1'b1);
        drain();

        // reset discards queued word; later rd_ready ignored
        cyc(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        cyc(1'b0, 1'b1, 32'h1234_5678, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b0);

        // empty push with reader ready
        cyc(1'b1, 1'b1, 32'hCAFE_F00D, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b0);
        drain();

        // random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            logic rn, we, rr;
            rn = ($urandom_range(0, 79) != 0);
            we = ($urandom_range(0, 99) < 55);
            rr = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
            cyc(rn, we, $urandom, rr);
        end
        drain();
        cyc(1'b1, 1'b0, '0, 1'b0);
        chk("sb_leftover", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rdq32_reader.md
RDQ32_READER -- requirements
Module: rdq32_reader

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 4, entry count; SHALL be a power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 r  input  1  reset; synchronous, active-low.
REQ-005 wr_en  input  1  writer pushes wr_data this cycle.
REQ-006 wr_data  input  WIDTH  word to enqueue.
REQ-007 wr_full  output  1  queue holds DEPTH entries.
REQ-008 rd_valid  output  1  rd_data holds a valid word for the reader.
REQ-009 rd_ready  input  1  reader accepts rd_data this cycle.
REQ-010 rd_data  output  WIDTH  head-of-queue word.
REQ-011 count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 ovf  output  1  sticky overflow flag.

Function
REQ-013 State SHALL be EMPTY (count=0), PARTIAL (0<count<DEPTH) or FULL (count=DEPTH), derived from count, with no separate state register.
REQ-014 pop = rd_valid & rd_ready; push = wr_en & (~wr_full | pop).
REQ-015 On push, wr_data SHALL be written at wr_ptr, and wr_ptr SHALL increment modulo DEPTH.
REQ-016 On pop, rd_ptr SHALL increment modulo DEPTH.
REQ-017 count SHALL update next edge: +1 on push only, -1 on pop only, and unchanged on both or neither.
REQ-018 rd_valid = (count!=0) in the base build; rd_data = entry[rd_ptr], combinational from registered state.
REQ-019 Write-to-read latency is 1 cycle: a word pushed in cycle N is first visible on rd_data in cycle N+1.
REQ-020 FULL with wr_en & pop in the same cycle: both SHALL occur; count stays DEPTH; no ovf.
REQ-021 FULL with wr_en & ~pop: the word is dropped, storage and pointers are unchanged, and ovf SHALL set next edge.
REQ-022 ovf SHALL stay at 1 until reset.
REQ-023 rd_ready while rd_valid=0 SHALL be ignored, with no pointer or count change.
REQ-024 rd_data SHALL be held stable while rd_valid=1 & rd_ready=0.
REQ-025 Pointer wrap from DEPTH-1 to 0 SHALL preserve FIFO order.

Reset
REQ-026 When r=0 at a rising clk edge: wr_ptr=0, rd_ptr=0, count=0, ovf=0; therefore rd_valid=0 and wr_full=0 the following cycle.
REQ-027 Reset SHALL override a simultaneous push or pop.
REQ-028 Reset mid-operation discards all queued words; storage contents need not be cleared.
REQ-029 wr_en and rd_ready asserted during reset SHALL have no effect.

Configuration
REQ-030 Macro RDQ32_BYPASS_EN SHALL control the empty-queue bypass path.
REQ-031 With RDQ32_BYPASS_EN defined: rd_valid = (count!=0) | wr_en; when count=0, rd_data = wr_data (zero latency).
REQ-032 With RDQ32_BYPASS_EN defined, an EMPTY-state push+pop SHALL pass the word straight through: it is not stored, pointers and count are unchanged.
REQ-033 With RDQ32_BYPASS_EN undefined, REQ-018/019 apply and no combinational path exists from wr_* to rd_*.

Verification
REQ-034 Reset then push 0x11111111, 0x22222222, 0x33333333 with rd_ready=0 -> count=3, rd_data=0x11111111, rd_valid=1.
REQ-035 Fill 4 entries, then wr_en=1 for 1 cycle with rd_ready=0 -> ovf=1, count=4; drain returns the first 4 words in order, and the dropped word is never seen.
REQ-036 FULL, wr_en=1 & rd_ready=1 for 6 cycles with values 0xA0..0xA5 -> count stays 4, no ovf, and the pops return the original 4 words followed by 0xA0, 0xA1 (wrap exercised).
REQ-037 Push 0xDEADBEEF then assert r=0 for 1 cycle -> count=0, rd_valid=0, ovf=0; a subsequent rd_ready has no effect.
REQ-038 Bypass build, EMPTY, wr_en=1, wr_data=0xCAFEF00D, rd_ready=1 -> rd_valid=1, rd_data=0xCAFEF00D same cycle; count stays 0. Base build: rd_valid=0 that cycle and 1 the next, with count=1.
